// File: rtl/card_click_decoder_pkg.sv
// rtl/card_click_decoder_pkg.sv - shared card grid constants, bus widths and card state codes
package card_click_decoder_pkg;

    localparam int CARD_ADDRESS_SIZE = 5;
    localparam int CARD_MAX_NUM_SIZE = 5;
    localparam int CARD_STATE_SIZE   = 2;
    localparam int CARD_COLOR_SIZE   = 12;
    localparam int POS_SIZE          = 12;
    localparam int REL_SIZE          = 13;
    localparam int IDX_SIZE          = 3;

    localparam int GRID_X0 = 92;
    localparam int GRID_Y0 = 100;
    localparam int CARD_W  = 120;
    localparam int CARD_H  = 140;
    localparam int PITCH_X = 144;
    localparam int PITCH_Y = 164;
    localparam int COLS    = 6;
    localparam int ROWS    = 4;

    typedef enum logic [CARD_STATE_SIZE-1:0] {
        CARD_EMPTY       = 2'b00,
        CARD_COVERED     = 2'b01,
        CARD_DEACTIVATED = 2'b10,
        CARD_DISCOVERED  = 2'b11
    } card_state_e;

    function automatic logic [CARD_ADDRESS_SIZE-1:0] grid_address(
        input logic [IDX_SIZE-1:0] row,
        input logic [IDX_SIZE-1:0] col
    );
        int a;
        a = int'(row) * COLS + int'(col);
        return a[CARD_ADDRESS_SIZE-1:0];
    endfunction

endpackage

// File: rtl/card_click_decoder_if.sv
// rtl/card_click_decoder_if.sv - card memory read port (address out, state/colour back one cycle later)
interface card_click_decoder_if;
    import card_click_decoder_pkg::*;

    logic [CARD_ADDRESS_SIZE-1:0] card_rd_address;
    logic [CARD_STATE_SIZE-1:0]   card_rd_state;
    logic [CARD_COLOR_SIZE-1:0]   card_rd_color;

    modport master (output card_rd_address, input card_rd_state, input card_rd_color);
    modport slave  (input card_rd_address, output card_rd_state, output card_rd_color);
endinterface

// File: rtl/card_click_decoder_locator.sv
// rtl/card_click_decoder_locator.sv - card_axis_locator: one grid axis, iterative subtract-and-count
module card_axis_locator
    import card_click_decoder_pkg::*;
#(
    parameter int ORIGIN  = 0,
    parameter int PITCH   = 1,
    parameter int SIZE    = 1,
    parameter int MAX_IDX = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step_en,
    input  logic [POS_SIZE-1:0] pos,
    output logic [IDX_SIZE-1:0] idx,
    output logic                stepping,
    output logic                miss
);
    localparam logic signed [REL_SIZE-1:0] ORIGIN_S  = REL_SIZE'(ORIGIN);
    localparam logic signed [REL_SIZE-1:0] PITCH_S   = REL_SIZE'(PITCH);
    localparam logic signed [REL_SIZE-1:0] SIZE_S    = REL_SIZE'(SIZE);
    localparam logic        [IDX_SIZE-1:0] MAX_IDX_U = IDX_SIZE'(MAX_IDX);

    logic signed [REL_SIZE-1:0] rel_q, rel_d;
    logic        [IDX_SIZE-1:0] idx_q, idx_d;

    always_comb begin
        stepping = step_en && (rel_q >= PITCH_S) && (idx_q < MAX_IDX_U);
        rel_d    = rel_q;
        idx_d    = idx_q;
        if (load) begin
            rel_d = $signed({1'b0, pos}) - ORIGIN_S;
            idx_d = '0;
        end else if (stepping) begin
            rel_d = rel_q - PITCH_S;
            idx_d = idx_q + 1'b1;
        end
    end

    // Residual is only meaningful once stepping has stopped; the last column/row keeps any excess.
    assign miss = rel_q[REL_SIZE-1] || (rel_q >= SIZE_S);
    assign idx  = idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rel_q <= '0;
            idx_q <= '0;
        end else begin
            rel_q <= rel_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/card_click_decoder.sv
// rtl/card_click_decoder.sv - turns a mouse click into a single pulse naming the covered card under the pointer
module card_click_decoder
    import card_click_decoder_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wait_for_click_en,
    input  logic [POS_SIZE-1:0]          mouse_xpos,
    input  logic [POS_SIZE-1:0]          mouse_ypos,
    input  logic                         mouse_left,
    input  logic [CARD_MAX_NUM_SIZE-1:0] num_of_cards,
    card_click_decoder_if.master         rd,
    output logic                         card_pressed,
    output logic [CARD_ADDRESS_SIZE-1:0] card_clicked_address,
    output logic [CARD_COLOR_SIZE-1:0]   card_clicked_color
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_ARMED, ST_LOCATE, ST_READ, ST_CHECK, ST_REPORT, ST_HOLD
    } fsm_state_e;

    fsm_state_e                   state_q, state_d;
    logic                         mouse_left_q, mouse_left_d;
    logic [CARD_ADDRESS_SIZE-1:0] rd_address_q, rd_address_d;
    logic [CARD_ADDRESS_SIZE-1:0] clicked_address_q, clicked_address_d;
    logic [CARD_COLOR_SIZE-1:0]   clicked_color_q, clicked_color_d;

    logic                         click_event, locate_load, locate_step;
    logic                         x_stepping, y_stepping, x_miss, y_miss, grid_miss;
    logic [IDX_SIZE-1:0]          col, row;
    logic [CARD_ADDRESS_SIZE-1:0] grid_addr;

    assign click_event = mouse_left && !mouse_left_q && wait_for_click_en;
    assign locate_load = (state_q == ST_ARMED) && click_event;
    assign locate_step = (state_q == ST_LOCATE);
    assign grid_addr   = grid_address(row, col);
    assign grid_miss   = x_miss || y_miss || (grid_addr >= num_of_cards);

    card_axis_locator #(
        .ORIGIN(GRID_X0), .PITCH(PITCH_X), .SIZE(CARD_W), .MAX_IDX(COLS - 1)
    ) u_x_locator (
        .clk(clk), .rst(rst), .load(locate_load), .step_en(locate_step),
        .pos(mouse_xpos), .idx(col), .stepping(x_stepping), .miss(x_miss)
    );

    card_axis_locator #(
        .ORIGIN(GRID_Y0), .PITCH(PITCH_Y), .SIZE(CARD_H), .MAX_IDX(ROWS - 1)
    ) u_y_locator (
        .clk(clk), .rst(rst), .load(locate_load), .step_en(locate_step),
        .pos(mouse_ypos), .idx(row), .stepping(y_stepping), .miss(y_miss)
    );

    always_comb begin
        state_d           = state_q;
        mouse_left_d      = mouse_left;
        rd_address_d      = rd_address_q;
        clicked_address_d = clicked_address_q;
        clicked_color_d   = clicked_color_q;
        card_pressed      = 1'b0;
        case (state_q)
            ST_IDLE:   if (wait_for_click_en) state_d = ST_ARMED;
            ST_ARMED: begin
                if (!wait_for_click_en) state_d = ST_IDLE;
                else if (click_event)   state_d = ST_LOCATE;
            end
            ST_LOCATE: begin
                if (!wait_for_click_en) begin
                    state_d = ST_IDLE;
                end else if (!x_stepping && !y_stepping) begin
                    if (grid_miss) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d      = ST_READ;
                        rd_address_d = grid_addr;
                    end
                end
            end
            ST_READ:   state_d = wait_for_click_en ? ST_CHECK : ST_IDLE;
            ST_CHECK: begin
                // Identity is captured on the way into REPORT so it is valid alongside the pulse.
                if (!wait_for_click_en) begin
                    state_d = ST_IDLE;
                end else if (rd.card_rd_state == CARD_COVERED) begin
                    state_d           = ST_REPORT;
                    clicked_address_d = rd_address_q;
                    clicked_color_d   = rd.card_rd_color;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_REPORT: begin
                card_pressed = 1'b1;
                state_d      = ST_HOLD;
            end
            ST_HOLD:   if (!wait_for_click_en) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            mouse_left_q      <= 1'b0;
            rd_address_q      <= '0;
            clicked_address_q <= '0;
            clicked_color_q   <= '0;
        end else begin
            state_q           <= state_d;
            mouse_left_q      <= mouse_left_d;
            rd_address_q      <= rd_address_d;
            clicked_address_q <= clicked_address_d;
            clicked_color_q   <= clicked_color_d;
        end
    end

    assign rd.card_rd_address   = rd_address_q;
    assign card_clicked_address = clicked_address_q;
    assign card_clicked_color   = clicked_color_q;

endmodule
